vga_timing_gen: RTL and testbench

Generates 800x600@60 Hz VGA raster timing in the 40 MHz pixel-clock domain produced by the system PLL. It consumes the PLL output clock and its `locked` flag. It drives hsync/vsync to the connector, plus data-enable, pixel coordinates and line/frame strobes to the pixel-source logic downstream. An optional prefetch port issues coordinates ahead of data-enable, so a pipelined frame-buffer read can return data in step with `de`.

---
 rtl/vga_timing_gen.sv | 176 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// vga_timing_gen
//   800x600@60 raster timing generator for the 40 MHz pixel clock (PLL
//   outclk_0). Two free-running counters (h, v) are decoded into registered
//   sync, data-enable, coordinate and strobe outputs. Every output after a
//   clock edge reflects the counter values held before that edge, so the first
//   edge out of reset already shows pixel (0,0).
//
//   Optional feature macro: VGA_TIMING_PREFETCH_EN
//     Adds req/req_x/req_y, a copy of de/x/y running LEAD cycles early, so a
//     pipelined frame-buffer read returns data aligned with de.
//
// Ports
//   refclk       in   pixel clock (only clock)
//   rst          in   synchronous active-high reset
//   locked       in   PLL lock; low is treated exactly like rst
//   hsync/vsync  out  syncs, active level H_POL / V_POL
//   de           out  active-video enable
//   x / y        out  pixel column / row while de, else 0
//   line_start   out  strobe at h==0
//   frame_start  out  strobe at h==0, v==0
//   req,req_x,req_y out  prefetch enable/coords (macro only)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_VISIBLE = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter bit H_POL     = 1'b1,
  parameter bit V_POL     = 1'b1,
  parameter int LEAD      = 2
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        locked,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_TIMING_PREFETCH_EN
  ,
  output logic        req,
  output logic [10:0] req_x,
  output logic [9:0]  req_y
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0]  VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  // Lead outside 1..64 would break the one-line lookahead assumption.
  if (LEAD < 1 || LEAD > 64) begin : g_bad_lead
    $error("vga_timing_gen: LEAD out of range 1..64");
  end

  // Loss of PLL lock is indistinguishable from reset.
  logic clr;
  assign clr = rst | ~locked;

  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic        h_last;
  logic [9:0]  v_inc;   // row after v_q, with frame wrap

  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        ls_q, ls_d;
  logic        fs_q, fs_d;

  assign h_last = (h_q == H_LAST);
  assign v_inc  = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;

  always_comb begin
    h_d     = h_last ? 11'd0 : h_q + 11'd1;
    v_d     = h_last ? v_inc : v_q;
    de_d    = (h_q < H_VIS) && (v_q < V_VIS);
    hsync_d = ((h_q >= HS_BEG) && (h_q < HS_END)) ? H_POL : ~H_POL;
    // vsync depends only on v, so it switches on whole-line boundaries.
    vsync_d = ((v_q >= VS_BEG) && (v_q < VS_END)) ? V_POL : ~V_POL;
    x_d     = de_d ? h_q : 11'd0;
    y_d     = de_d ? v_q : 10'd0;
    ls_d    = (h_q == 11'd0);
    fs_d    = (h_q == 11'd0) && (v_q == 10'd0);
  end

  always_ff @(posedge refclk) begin
    if (clr) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

`ifdef VGA_TIMING_PREFETCH_EN
  // Lookahead position (h+LEAD, v), wrapping into the next line/frame.
  logic [11:0] p_sum;
  logic        p_wrap;
  logic [10:0] p_h;
  logic [9:0]  p_v;
  logic        req_q, req_d;
  logic [10:0] req_x_q, req_x_d;
  logic [9:0]  req_y_q, req_y_d;

  assign p_sum  = {1'b0, h_q} + 12'(LEAD);
  assign p_wrap = (p_sum >= 12'(H_TOTAL));
  assign p_h    = p_wrap ? 11'(p_sum - 12'(H_TOTAL)) : p_sum[10:0];
  assign p_v    = p_wrap ? v_inc : v_q;

  always_comb begin
    req_d   = (p_h < H_VIS) && (p_v < V_VIS);
    req_x_d = req_d ? p_h : 11'd0;
    req_y_d = req_d ? p_v : 10'd0;
  end

  always_ff @(posedge refclk) begin
    if (clr) begin
      req_q   <= 1'b0;
      req_x_q <= '0;
      req_y_q <= '0;
    end else begin
      req_q   <= req_d;
      req_x_q <= req_x_d;
      req_y_q <= req_y_d;
    end
  end

  assign req   = req_q;
  assign req_x = req_x_q;
  assign req_y = req_y_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Directed bench for vga_timing_gen.
//   u0: default 800x600 timing, active-high syncs (line timing, reset, lock loss).
//   u1: same horizontal timing, shortened vertical (6/1/2/2 -> 11 lines) and
//       active-low syncs, so a whole frame fits in a short run.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, locked0, rst1, locked1;
  logic hs0, vs0, de0, ls0, fs0, hs1, vs1, de1, ls1, fs1;
  logic [10:0] x0, x1;
  logic [9:0]  y0, y1;
`ifdef VGA_TIMING_PREFETCH_EN
  logic rq0, rq1;
  logic [10:0] rqx0, rqx1;
  logic [9:0]  rqy0, rqy1;
`endif

  vga_timing_gen u0 (
    .refclk(clk), .rst(rst0), .locked(locked0),
    .hsync(hs0), .vsync(vs0), .de(de0), .x(x0), .y(y0),
    .line_start(ls0), .frame_start(fs0)
`ifdef VGA_TIMING_PREFETCH_EN
    , .req(rq0), .req_x(rqx0), .req_y(rqy0)
`endif
  );

  vga_timing_gen #(
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b0), .V_POL(1'b0)
  ) u1 (
    .refclk(clk), .rst(rst1), .locked(locked1),
    .hsync(hs1), .vsync(vs1), .de(de1), .x(x1), .y(y1),
    .line_start(ls1), .frame_start(fs1)
`ifdef VGA_TIMING_PREFETCH_EN
    , .req(rq1), .req_x(rqx1), .req_y(rqy1)
`endif
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int de_cnt, xerr, hs_cnt, hs_first, ls_cnt, ls_t, vs_cnt, vs_first, fs_cnt, fs_last, ymax;
    bit found;

    rst0 = 1'b1; locked0 = 1'b1; rst1 = 1'b1; locked1 = 1'b1;
    repeat (5) step();
    chk("rst_de", de0, 0);     chk("rst_x", x0, 0);   chk("rst_y", y0, 0);
    chk("rst_hs", hs0, 0);     chk("rst_vs", vs0, 0);
    chk("rst_ls", ls0, 0);     chk("rst_fs", fs0, 0);
    chk("rst_hs_lowpol", hs1, 1);
    chk("rst_vs_lowpol", vs1, 1);
`ifdef VGA_TIMING_PREFETCH_EN
    chk("rst_req", rq0, 0);
`endif

    // First edge after release shows pixel (0,0) with both strobes.
    rst0 = 1'b0;
    step();
    chk("e0_de", de0, 1); chk("e0_x", x0, 0); chk("e0_y", y0, 0);
    chk("e0_ls", ls0, 1); chk("e0_fs", fs0, 1);
    step();
    chk("e1_x", x0, 1); chk("e1_fs", fs0, 0); chk("e1_ls", ls0, 0);

    // Two full lines of measurement; t = edge index since release.
    de_cnt = 2; xerr = 0; hs_cnt = 0; hs_first = -1; ls_cnt = 0; ls_t = -1;
    for (int t = 2; t < 2112; t++) begin
      step();
      if (t < 1056) begin
        if (de0) begin
          de_cnt++;
          if (x0 != 11'(t)) xerr++;
        end
        if (hs0) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = t;
        end
      end
      if (ls0) begin ls_cnt++; if (ls_t < 0) ls_t = t; end
      if (t == 1056) begin
        chk("l1_de", de0, 1); chk("l1_x", x0, 0); chk("l1_y", y0, 1);
      end
      if (t == 1900) chk("l1_blank_x", x0, 0);
`ifdef VGA_TIMING_PREFETCH_EN
      if (t == 797) begin chk("pf_797_req", rq0, 1); chk("pf_797_x", rqx0, 799); end
      if (t == 798) chk("pf_798_req", rq0, 0);
      if (t == 1054) begin
        chk("pf_1054_req", rq0, 1); chk("pf_1054_x", rqx0, 0); chk("pf_1054_y", rqy0, 1);
        chk("pf_1054_de", de0, 0);
      end
`endif
    end
    chk("de_len", de_cnt, 800);
    chk("x_ramp_err", xerr, 0);
    chk("hs_start", hs_first, 840);
    chk("hs_len", hs_cnt, 128);
    chk("ls_count", ls_cnt, 1);
    chk("ls_period", ls_t, 1056);

    // Lock loss mid-line on row 2, column 400.
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      step();
      if (x0 == 11'd400 && y0 == 10'd2) found = 1'b1;
    end
    chk("lk_reach", found, 1);
    locked0 = 1'b0;
    step();
    chk("lk_de", de0, 0); chk("lk_x", x0, 0); chk("lk_y", y0, 0);
    chk("lk_hs", hs0, 0); chk("lk_vs", vs0, 0);
    chk("lk_ls", ls0, 0); chk("lk_fs", fs0, 0);
`ifdef VGA_TIMING_PREFETCH_EN
    chk("lk_req", rq0, 0); chk("lk_reqx", rqx0, 0);
`endif
    step();
    chk("lk_hold_de", de0, 0);
    locked0 = 1'b1;
    step();
    chk("rl_fs", fs0, 1); chk("rl_x", x0, 0); chk("rl_y", y0, 0); chk("rl_de", de0, 1);
    step();
    chk("rl_x1", x0, 1);

    // rst and locked low together act like either alone.
    rst0 = 1'b1; locked0 = 1'b0;
    step();
    chk("both_de", de0, 0); chk("both_x", x0, 0);
    rst0 = 1'b0; locked0 = 1'b1;
    step();
    chk("both_rel_fs", fs0, 1);

    // Full short frame on u1 with active-low syncs.
    rst1 = 1'b0;
    hs_cnt = 0; hs_first = -1; vs_cnt = 0; vs_first = -1;
    fs_cnt = 0; fs_last = -1; ymax = 0;
    for (int t = 0; t <= 11616; t++) begin
      step();
      if (t < 1056 && !hs1) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = t;
      end
      if (t < 11616 && !vs1) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = t;
      end
      if (fs1) begin fs_cnt++; fs_last = t; end
      if (int'(y1) > ymax) ymax = int'(y1);
`ifdef VGA_TIMING_PREFETCH_EN
      if (t == 4*1056 + 1054) begin chk("pf_l4_req", rq1, 1); chk("pf_l4_y", rqy1, 5); end
      if (t == 5*1056 + 1054) chk("pf_lastvis_req", rq1, 0);
      if (t == 10*1056 + 1054) begin
        chk("pf_wrap_req", rq1, 1); chk("pf_wrap_x", rqx1, 0); chk("pf_wrap_y", rqy1, 0);
      end
`endif
    end
    chk("p_hs_start", hs_first, 840);
    chk("p_hs_len", hs_cnt, 128);
    chk("p_vs_start", vs_first, 7392);
    chk("p_vs_len", vs_cnt, 2112);
    chk("p_fs_count", fs_cnt, 2);
    chk("p_fs_period", fs_last, 11616);
    chk("p_ymax", ymax, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
